// File: rtl/pkt_chk_pkg.sv
// ============================================================================
// Module   : pkt_chk_pkg
// Brief    : Shared types and channel codes for the pkt_chk_d framing checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pkt_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [1:0] CH_A   = 2'd0;
    localparam logic [1:0] CH_B   = 2'd1;
    localparam logic [1:0] CH_C   = 2'd2;
    localparam logic [1:0] CH_BAD = 2'd3;

    typedef struct packed {
        logic       vld;
        logic       sop;
        logic       eop;
        logic [7:0] data;
        logic [1:0] chan;
    } beat_t;

endpackage

`default_nettype wire

// File: rtl/sat_cnt.sv
// ============================================================================
// Module   : sat_cnt
// Brief    : CNT_W-bit counter with a 2-bit increment that sticks at all-ones.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_cnt
    import pkt_chk_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   w_sum;

    always_comb begin
        w_sum = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc_i};
        cnt_d = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pkt_chk_d.sv
// ============================================================================
// Module   : pkt_chk_d
// Brief    : Framing checker / statistics stage behind the fifo_p merger.
//            Statistics counters are built only when PKT_CHK_STAT_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pkt_chk_d #(
    parameter int MAX_LEN = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_d_vld,
    input  logic             data_d_sop,
    input  logic             data_d_eop,
    input  logic [7:0]       data_d,
    input  logic [1:0]       chan_d,
    output logic             data_o_vld,
    output logic             data_o_sop,
    output logic             data_o_eop,
    output logic [7:0]       data_o,
    output logic [1:0]       chan_o,
    output logic             data_o_err,
    output logic [CNT_W-1:0] pkt_cnt_a,
    output logic [CNT_W-1:0] pkt_cnt_b,
    output logic [CNT_W-1:0] pkt_cnt_c,
    output logic [CNT_W-1:0] err_cnt
);

    import pkt_chk_pkg::*;

    localparam logic [7:0] c_MAX_LEN = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    beat_t      s1_q;
    logic       s1_full_q;
    logic       s1_err_q;

    logic       o_vld_q, o_sop_q, o_eop_q, o_err_q;
    logic [7:0] o_data_q;
    logic [1:0] o_chan_q;

    beat_t      w_in;
    beat_t      w_cap_beat;
    logic [7:0] w_len_nxt;
    logic       w_rel, w_rel_eop, w_rel_err;
    logic       w_cap, w_cap_eop, w_cap_err;
    logic       w_start;
    logic       w_err_new;

    assign w_in      = {data_d_vld, data_d_sop, data_d_eop, data_d, chan_d};
    assign w_len_nxt = len_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        w_rel     = 1'b0;
        w_rel_eop = s1_q.eop;
        w_rel_err = s1_err_q;
        w_cap     = 1'b0;
        w_cap_eop = w_in.eop;
        w_cap_err = 1'b0;
        w_start   = 1'b0;
        w_err_new = 1'b0;

        // Outside PKT the holding register only ever holds an EOP beat
        // waiting for its one-cycle release.
        if (state_q != ST_PKT && s1_full_q && s1_q.vld && s1_q.eop) begin
            w_rel = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_in.vld) begin
                    w_start = 1'b1;
                end
            end
            ST_DROP: begin
                if (w_in.vld) begin
                    if (w_in.sop) begin
                        w_start = 1'b1;
                    end else if (w_in.eop) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PKT: begin
                if (w_in.vld) begin
                    w_rel = 1'b1;
                    if (w_in.sop || (w_in.chan != s1_q.chan)) begin
                        // Truncate: held beat leaves as a forced, errored EOP.
                        w_rel_eop = 1'b1;
                        w_rel_err = 1'b1;
                        w_start   = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        w_cap = 1'b1;
                        len_d = w_len_nxt;
                        if (w_in.eop) begin
                            state_d = ST_IDLE;
                        end else if (w_len_nxt == c_MAX_LEN) begin
                            w_cap_eop = 1'b1;
                            w_cap_err = 1'b1;
                            state_d   = ST_DROP;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_start) begin
            if (!w_in.sop) begin
                w_err_new = 1'b1;
                state_d   = ST_IDLE;
            end else if (w_in.chan == CH_BAD) begin
                w_err_new = 1'b1;
                state_d   = ST_DROP;
            end else begin
                w_cap     = 1'b1;
                w_cap_eop = w_in.eop;
                len_d     = 8'd1;
                state_d   = w_in.eop ? ST_IDLE : ST_PKT;
            end
        end
    end

    always_comb begin
        w_cap_beat     = w_in;
        w_cap_beat.eop = w_cap_eop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            s1_q      <= '0;
            s1_full_q <= 1'b0;
            s1_err_q  <= 1'b0;
            o_vld_q   <= 1'b0;
            o_sop_q   <= 1'b0;
            o_eop_q   <= 1'b0;
            o_err_q   <= 1'b0;
            o_data_q  <= '0;
            o_chan_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            if (w_cap) begin
                s1_q      <= w_cap_beat;
                s1_full_q <= 1'b1;
                s1_err_q  <= w_cap_err;
            end else if (w_rel) begin
                s1_full_q <= 1'b0;
            end
            o_vld_q  <= w_rel;
            o_sop_q  <= w_rel & s1_q.sop;
            o_eop_q  <= w_rel & w_rel_eop;
            o_err_q  <= w_rel & w_rel_eop & w_rel_err;
            o_data_q <= w_rel ? s1_q.data : 8'd0;
            o_chan_q <= w_rel ? s1_q.chan : 2'd0;
        end
    end

    assign data_o_vld = o_vld_q;
    assign data_o_sop = o_sop_q;
    assign data_o_eop = o_eop_q;
    assign data_o_err = o_err_q;
    assign data_o     = o_data_q;
    assign chan_o     = o_chan_q;

`ifdef PKT_CHK_STAT_EN
    logic       w_rel_good;
    logic [1:0] w_inc_a, w_inc_b, w_inc_c, w_inc_err;

    assign w_rel_good = w_rel & w_rel_eop & ~w_rel_err;
    assign w_inc_a    = {1'b0, w_rel_good & (s1_q.chan == CH_A)};
    assign w_inc_b    = {1'b0, w_rel_good & (s1_q.chan == CH_B)};
    assign w_inc_c    = {1'b0, w_rel_good & (s1_q.chan == CH_C)};
    // A truncation and an illegal new sop can land on the same edge.
    assign w_inc_err  = {1'b0, w_rel & w_rel_eop & w_rel_err} + {1'b0, w_err_new};

    sat_cnt #(.CNT_W(CNT_W)) u_cnt_a (.clk(clk), .rst_n(rst_n), .inc_i(w_inc_a),   .cnt_o(pkt_cnt_a));
    sat_cnt #(.CNT_W(CNT_W)) u_cnt_b (.clk(clk), .rst_n(rst_n), .inc_i(w_inc_b),   .cnt_o(pkt_cnt_b));
    sat_cnt #(.CNT_W(CNT_W)) u_cnt_c (.clk(clk), .rst_n(rst_n), .inc_i(w_inc_c),   .cnt_o(pkt_cnt_c));
    sat_cnt #(.CNT_W(CNT_W)) u_cnt_e (.clk(clk), .rst_n(rst_n), .inc_i(w_inc_err), .cnt_o(err_cnt));
`else
    logic w_stat_unused;
    assign w_stat_unused = w_err_new;
    assign pkt_cnt_a     = '0;
    assign pkt_cnt_b     = '0;
    assign pkt_cnt_c     = '0;
    assign err_cnt       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pkt_chk_d.sv
// ============================================================================
// Module   : tb_pkt_chk_d
// Brief    : Self-checking bench for pkt_chk_d (packet table + scoreboard).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pkt_chk_d;

    localparam int MAX_LEN = 32;
    localparam int CNT_W   = 16;
`ifdef PKT_CHK_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             vld, sop, eop;
    logic [7:0]       din;
    logic [1:0]       cin;
    logic             data_o_vld, data_o_sop, data_o_eop, data_o_err;
    logic [7:0]       data_o;
    logic [1:0]       chan_o;
    logic [CNT_W-1:0] pkt_cnt_a, pkt_cnt_b, pkt_cnt_c, err_cnt;

    always #5 clk = ~clk;

    pkt_chk_d #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_d_vld (vld),
        .data_d_sop (sop),
        .data_d_eop (eop),
        .data_d     (din),
        .chan_d     (cin),
        .data_o_vld (data_o_vld),
        .data_o_sop (data_o_sop),
        .data_o_eop (data_o_eop),
        .data_o     (data_o),
        .chan_o     (chan_o),
        .data_o_err (data_o_err),
        .pkt_cnt_a  (pkt_cnt_a),
        .pkt_cnt_b  (pkt_cnt_b),
        .pkt_cnt_c  (pkt_cnt_c),
        .err_cnt    (err_cnt)
    );

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
        logic [1:0] chan;
        logic       err;
    } exp_t;

    typedef struct {
        int chan;
        int first;
        int nb;
        bit sop;
        bit eop;
        int gap;
        int ea, eb, ec, ee;
    } row_t;

    exp_t sb[$];
    int   n_tot = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_tot++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Beat-level reference: 0=idle, 1=in packet, 2=dropping
    int   m_state = 0;
    int   m_len   = 0;
    exp_t m_held;

    task automatic m_start(input logic s, input logic e, input logic [7:0] d, input logic [1:0] c);
        if (!s) begin
            m_state = 0;
        end else if (c == 2'd3) begin
            m_state = 2;
        end else if (e) begin
            sb.push_back({1'b1, 1'b1, d, c, 1'b0});
            m_state = 0;
        end else begin
            m_held  = {1'b1, 1'b0, d, c, 1'b0};
            m_len   = 1;
            m_state = 1;
        end
    endtask

    task automatic m_beat(input logic s, input logic e, input logic [7:0] d, input logic [1:0] c);
        case (m_state)
            0: m_start(s, e, d, c);
            2: begin
                if (s) m_start(s, e, d, c);
                else if (e) m_state = 0;
            end
            default: begin
                if (s || c != m_held.chan) begin
                    m_held.eop = 1'b1;
                    m_held.err = 1'b1;
                    sb.push_back(m_held);
                    m_start(s, e, d, c);
                end else begin
                    sb.push_back(m_held);
                    m_len++;
                    if (e) begin
                        sb.push_back({1'b0, 1'b1, d, c, 1'b0});
                        m_state = 0;
                    end else if (m_len == MAX_LEN) begin
                        sb.push_back({1'b0, 1'b1, d, c, 1'b1});
                        m_state = 2;
                    end else begin
                        m_held = {1'b0, 1'b0, d, c, 1'b0};
                    end
                end
            end
        endcase
    endtask

    task automatic drive_beat(input logic s, input logic e, input logic [7:0] d, input logic [1:0] c);
        vld = 1'b1; sop = s; eop = e; din = d; cin = c;
        @(posedge clk);
        m_beat(s, e, d, c);
        #1;
        vld = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input int ea, input int eb, input int ec, input int ee);
        check({tag, "_cnt_a"}, pkt_cnt_a, STAT_EN ? ea : 0);
        check({tag, "_cnt_b"}, pkt_cnt_b, STAT_EN ? eb : 0);
        check({tag, "_cnt_c"}, pkt_cnt_c, STAT_EN ? ec : 0);
        check({tag, "_err"},   err_cnt,   STAT_EN ? ee : 0);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1) begin
            if (data_o_vld) begin
                if (sb.size() == 0) begin
                    n_tot++;
                    n_bad++;
                    $display("FAIL unexpected_beat: actual data=%0h chan=%0d required none", data_o, chan_o);
                end else begin
                    e = sb.pop_front();
                    check("out_beat", {data_o_sop, data_o_eop, data_o, chan_o, data_o_err}, e);
                end
            end else begin
                check("idle_flags", {data_o_sop, data_o_eop, data_o_err}, 3'b000);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        row_t rows[10];
        rows[0] = '{0,   0, 16, 1'b1, 1'b1, 0, 1, 0, 0, 0};
        rows[1] = '{1,  20, 21, 1'b1, 1'b1, 3, 1, 1, 0, 0};
        rows[2] = '{2,  50, 31, 1'b1, 1'b1, 3, 1, 1, 1, 0};
        rows[3] = '{0,   0,  6, 1'b1, 1'b0, 0, 1, 1, 1, 0};
        rows[4] = '{1,   9,  4, 1'b1, 1'b1, 0, 1, 2, 1, 1};
        rows[5] = '{2, 100, 40, 1'b1, 1'b1, 0, 1, 2, 1, 2};
        rows[6] = '{0,   7,  1, 1'b1, 1'b1, 0, 2, 2, 1, 2};
        rows[7] = '{1, 200,  3, 1'b0, 1'b0, 0, 2, 2, 1, 5};
        rows[8] = '{3,  60,  4, 1'b1, 1'b1, 0, 2, 2, 1, 6};
        rows[9] = '{2,   0, 32, 1'b1, 1'b1, 0, 2, 2, 2, 6};

        rst_n = 1'b0; vld = 1'b0; sop = 1'b0; eop = 1'b0; din = '0; cin = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {data_o_vld, data_o_sop, data_o_eop, data_o, chan_o, data_o_err,
                              pkt_cnt_a, pkt_cnt_b, pkt_cnt_c, err_cnt}, '0);
        rst_n = 1'b1;
        idle(2);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < rows[r].nb; i++) begin
                drive_beat(rows[r].sop && i == 0, rows[r].eop && i == rows[r].nb - 1,
                           8'(rows[r].first + i), 2'(rows[r].chan));
                if (rows[r].gap > 0) idle(rows[r].gap);
            end
            idle(6);
            check_cnt($sformatf("row%0d", r), rows[r].ea, rows[r].eb, rows[r].ec, rows[r].ee);
        end

        // EOP beat leaves exactly one cycle after its sampling edge
        drive_beat(1'b1, 1'b1, 8'hAB, 2'd1);
        @(negedge clk); #1;
        check("lat_not_early", data_o_vld, 1'b0);
        @(negedge clk); #1;
        check("lat_eop", {data_o_vld, data_o_eop, data_o}, {1'b1, 1'b1, 8'hAB});
        @(posedge clk); #1;
        idle(4);

        // Channel switch without sop: truncation plus an orphan beat
        drive_beat(1'b1, 1'b0, 8'h10, 2'd0);
        drive_beat(1'b0, 1'b0, 8'h11, 2'd0);
        drive_beat(1'b0, 1'b0, 8'h12, 2'd1);
        idle(6);
        check_cnt("chan_switch", 2, 3, 2, 8);

        // Illegal sop mid-packet, then a good sop while still dropping
        drive_beat(1'b1, 1'b0, 8'h20, 2'd0);
        drive_beat(1'b0, 1'b0, 8'h21, 2'd0);
        drive_beat(1'b1, 1'b0, 8'h22, 2'd3);
        drive_beat(1'b0, 1'b0, 8'h23, 2'd3);
        drive_beat(1'b1, 1'b1, 8'h24, 2'd0);
        idle(6);
        check_cnt("bad_sop_in_pkt", 3, 3, 2, 10);

        // Reset after beat 7 of a 16-beat packet
        for (int i = 0; i < 7; i++) drive_beat(i == 0, 1'b0, 8'(i), 2'd2);
        @(negedge clk); #1;
        check("pre_reset_drain", sb.size(), 0);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {data_o_vld, data_o_sop, data_o_eop, data_o, chan_o, data_o_err,
                                    pkt_cnt_a, pkt_cnt_b, pkt_cnt_c, err_cnt}, '0);
        sb.delete();
        m_state = 0;
        m_len   = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < 16; i++) drive_beat(i == 0, i == 15, 8'(i + 8'h40), 2'd0);
        idle(6);
        check_cnt("after_reset", 1, 0, 0, 0);

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
